// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store initiator with request/response handshake for a word-addressed data memory
//
// Ports:
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_reqValid/o_reqReady   request handshake; request accepted on valid & ready
//   i_reqWrite              1 = store, 0 = load
//   i_reqSize               00 byte, 01 half, 10 word, 11 illegal
//   i_reqSigned             sign-extend sub-word loads (only with LOAD_SIGNEXT_EN)
//   i_reqAddr, i_reqData    byte address, right-aligned store data
//   o_rspValid              one-cycle response strobe
//   o_rspData, o_rspErr     load result (0 for stores/errors), misaligned/illegal flag
//   o_memWrEn, o_memAddr    memory write enable, word-aligned memory address
//   o_memDataIn             memory write data
//   i_memDataOut            combinational memory read data
//
// Build option: LOAD_SIGNEXT_EN enables sign extension of byte/half loads.
module mem_access_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_reqValid,
    output logic        o_reqReady,
    input  logic        i_reqWrite,
    input  logic [1:0]  i_reqSize,
    input  logic        i_reqSigned,
    input  logic [31:0] i_reqAddr,
    input  logic [31:0] i_reqData,
    output logic        o_rspValid,
    output logic [31:0] o_rspData,
    output logic        o_rspErr,
    output logic        o_memWrEn,
    output logic [31:0] o_memAddr,
    output logic [31:0] o_memDataIn,
    input  logic [31:0] i_memDataOut
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t      r_state, w_next;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_word;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
`ifdef LOAD_SIGNEXT_EN
    logic        r_signed;
`else
    logic        w_unused_signed;
    assign w_unused_signed = i_reqSigned;
`endif

    logic        w_accept;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_ext_b;
    logic        w_ext_h;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept   = (r_state == S_IDLE) && i_reqValid;
    assign o_rspData  = r_rsp_data;
    assign o_rspErr   = r_rsp_err;

    always_comb begin
        case (i_reqSize)
            2'b01:   w_req_err = i_reqAddr[0];
            2'b10:   w_req_err = |i_reqAddr[1:0];
            2'b11:   w_req_err = 1'b1;
            default: w_req_err = 1'b0;
        endcase
    end

    // Little-endian lane extraction from the live memory read during READ.
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = i_memDataOut[7:0];
            2'd1:    w_byte = i_memDataOut[15:8];
            2'd2:    w_byte = i_memDataOut[23:16];
            default: w_byte = i_memDataOut[31:24];
        endcase
        w_half  = r_addr[1] ? i_memDataOut[31:16] : i_memDataOut[15:0];
        w_ext_b = 1'b0;
        w_ext_h = 1'b0;
`ifdef LOAD_SIGNEXT_EN
        w_ext_b = r_signed & w_byte[7];
        w_ext_h = r_signed & w_half[15];
`endif
        case (r_size)
            2'b00:   w_load = {{24{w_ext_b}}, w_byte};
            2'b01:   w_load = {{16{w_ext_h}}, w_half};
            default: w_load = i_memDataOut;
        endcase
    end

    // Sub-word stores patch the captured word; word stores bypass it.
    always_comb begin
        w_merged = r_word;
        case (r_size)
            2'b00: begin
                case (r_addr[1:0])
                    2'd0:    w_merged[7:0]   = r_data[7:0];
                    2'd1:    w_merged[15:8]  = r_data[7:0];
                    2'd2:    w_merged[23:16] = r_data[7:0];
                    default: w_merged[31:24] = r_data[7:0];
                endcase
            end
            2'b01: begin
                if (r_addr[1]) w_merged[31:16] = r_data[15:0];
                else           w_merged[15:0]  = r_data[15:0];
            end
            default: w_merged = r_data;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        o_reqReady  = 1'b0;
        o_rspValid  = 1'b0;
        o_memWrEn   = 1'b0;
        o_memAddr   = 32'd0;
        o_memDataIn = 32'd0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset so ready stays low while reset is held.
                o_reqReady = ~i_rst;
                if (i_reqValid) begin
                    if (w_req_err)                              w_next = S_RESP;
                    else if (i_reqWrite && i_reqSize == 2'b10)  w_next = S_WRITE;
                    else                                        w_next = S_READ;
                end
            end
            S_READ: begin
                o_memAddr = {r_addr[31:2], 2'b00};
                w_next    = r_write ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                o_memWrEn   = 1'b1;
                o_memAddr   = {r_addr[31:2], 2'b00};
                o_memDataIn = w_merged;
                w_next      = S_RESP;
            end
            default: begin
                o_rspValid = 1'b1;
                w_next     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
            r_word     <= 32'd0;
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
`ifdef LOAD_SIGNEXT_EN
            r_signed   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= i_reqWrite;
                r_size  <= i_reqSize;
                r_addr  <= i_reqAddr;
                r_data  <= i_reqData;
`ifdef LOAD_SIGNEXT_EN
                r_signed <= i_reqSigned;
`endif
                if (w_req_err) begin
                    r_rsp_data <= 32'd0;
                    r_rsp_err  <= 1'b1;
                end
            end
            // Response registers change only on the edge entering RESP.
            if (r_state == S_READ) begin
                r_word <= i_memDataOut;
                if (!r_write) begin
                    r_rsp_data <= w_load;
                    r_rsp_err  <= 1'b0;
                end
            end
            if (r_state == S_WRITE) begin
                r_rsp_data <= 32'd0;
                r_rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl with a behavioural data memory
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqSigned = 1'b0;
    logic [31:0] reqAddr = 32'd0;
    logic [31:0] reqData = 32'd0;
    logic        rspValid;
    logic [31:0] rspData;
    logic        rspErr;
    logic        memWrEn;
    logic [31:0] memAddr;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;

    logic [31:0] mem [0:15];
    logic        pk_en = 1'b0;
    logic [3:0]  pk_idx = 4'd0;
    logic [31:0] pk_val = 32'd0;

    int n_vec = 0;
    int n_bad = 0;

    int          x_rsp_cyc;
    int          x_wr_cyc;
    int          x_wr_cnt;
    logic [31:0] x_wr_data;
    logic [31:0] x_rdata;
    logic        x_err;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pk_en)        mem[pk_idx] <= pk_val;
        else if (memWrEn) mem[memAddr[5:2]] <= memDataIn;
    end
    assign memDataOut = mem[memAddr[5:2]];

    mem_access_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_reqValid   (reqValid),
        .o_reqReady   (reqReady),
        .i_reqWrite   (reqWrite),
        .i_reqSize    (reqSize),
        .i_reqSigned  (reqSigned),
        .i_reqAddr    (reqAddr),
        .i_reqData    (reqData),
        .o_rspValid   (rspValid),
        .o_rspData    (rspData),
        .o_rspErr     (rspErr),
        .o_memWrEn    (memWrEn),
        .o_memAddr    (memAddr),
        .o_memDataIn  (memDataIn),
        .i_memDataOut (memDataOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        pk_en  = 1'b1;
        pk_idx = idx;
        pk_val = val;
        @(posedge clk);
        #1 pk_en = 1'b0;
    endtask

    // Issues one request and records, relative to the accept edge, the
    // cycle of the response strobe and of any memory write.
    task automatic xact(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] data);
        int n;
        x_rsp_cyc = -1;
        x_wr_cyc  = -1;
        x_wr_cnt  = 0;
        x_wr_data = 32'hx;
        x_rdata   = 32'hx;
        x_err     = 1'bx;
        @(negedge clk);
        reqWrite  = wr;
        reqSize   = sz;
        reqSigned = sg;
        reqAddr   = addr;
        reqData   = data;
        reqValid  = 1'b1;
        n = 0;
        while (!reqReady && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady) begin
            chk("accept_timeout", 32'd0, 32'd1);
            reqValid = 1'b0;
        end else begin
            @(posedge clk);
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c == 1) reqValid = 1'b0;
                if (memWrEn) begin
                    x_wr_cnt++;
                    x_wr_cyc  = c;
                    x_wr_data = memDataIn;
                end
                if (rspValid) begin
                    x_rsp_cyc = c;
                    x_rdata   = rspData;
                    x_err     = rspErr;
                    break;
                end
            end
        end
    endtask

    logic [5:0]  rdy_pat;
    logic [5:0]  rsp_pat;
    logic [31:0] d1, d2;
    int          rst_wr, rst_rsp;

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_reqReady", {31'd0, reqReady}, 32'd0);
        chk("rst_rspValid", {31'd0, rspValid}, 32'd0);
        chk("rst_rspData", rspData, 32'd0);
        chk("rst_rspErr", {31'd0, rspErr}, 32'd0);
        chk("rst_memWrEn", {31'd0, memWrEn}, 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memDataIn", memDataIn, 32'd0);
        rst = 1'b0;
        #1 chk("rel_reqReady", {31'd0, reqReady}, 32'd1);

        poke(4'd1, 32'h0000_0000);

        // Word store then load
        xact(1'b1, 2'b10, 1'b0, 32'd4, 32'hDEADBEEF);
        chk("wst_rsp_cyc", x_rsp_cyc, 32'd2);
        chk("wst_wr_cyc", x_wr_cyc, 32'd1);
        chk("wst_wr_cnt", x_wr_cnt, 32'd1);
        chk("wst_rspData", x_rdata, 32'd0);
        chk("wst_rspErr", {31'd0, x_err}, 32'd0);
        chk("wst_mem1", mem[1], 32'hDEADBEEF);
        xact(1'b0, 2'b10, 1'b0, 32'd4, 32'd0);
        chk("wld_rsp_cyc", x_rsp_cyc, 32'd2);
        chk("wld_wr_cnt", x_wr_cnt, 32'd0);
        chk("wld_rspData", x_rdata, 32'hDEADBEEF);

        // Byte and half read-modify-write
        poke(4'd2, 32'h11223344);
        xact(1'b1, 2'b00, 1'b0, 32'd9, 32'hFFFF_FFAA);
        chk("bst_wr_cyc", x_wr_cyc, 32'd2);
        chk("bst_wr_cnt", x_wr_cnt, 32'd1);
        chk("bst_wr_data", x_wr_data, 32'h1122AA44);
        chk("bst_rsp_cyc", x_rsp_cyc, 32'd3);
        chk("bst_mem2", mem[2], 32'h1122AA44);
        xact(1'b1, 2'b01, 1'b0, 32'd10, 32'h1234BEEF);
        chk("hst_wr_data", x_wr_data, 32'hBEEFAA44);
        chk("hst_rsp_cyc", x_rsp_cyc, 32'd3);
        chk("hst_mem2", mem[2], 32'hBEEFAA44);

        // Sub-word loads
        poke(4'd3, 32'h80F0007F);
        xact(1'b0, 2'b00, 1'b0, 32'd12, 32'd0);
        chk("bld12", x_rdata, 32'h0000007F);
        xact(1'b0, 2'b00, 1'b1, 32'd14, 32'd0);
`ifdef LOAD_SIGNEXT_EN
        chk("bld14_s", x_rdata, 32'hFFFFFFF0);
`else
        chk("bld14_s", x_rdata, 32'h000000F0);
`endif
        xact(1'b0, 2'b01, 1'b1, 32'd14, 32'd0);
`ifdef LOAD_SIGNEXT_EN
        chk("hld14_s", x_rdata, 32'hFFFF80F0);
`else
        chk("hld14_s", x_rdata, 32'h000080F0);
`endif
        xact(1'b0, 2'b00, 1'b0, 32'd15, 32'd0);
        chk("bld15_u", x_rdata, 32'h00000080);
        chk("bld15_rsp_cyc", x_rsp_cyc, 32'd2);

        // Error requests
        xact(1'b1, 2'b10, 1'b0, 32'd6, 32'h55555555);
        chk("err_mis_rsp_cyc", x_rsp_cyc, 32'd1);
        chk("err_mis_rspErr", {31'd0, x_err}, 32'd1);
        chk("err_mis_wr_cnt", x_wr_cnt, 32'd0);
        chk("err_mis_rspData", x_rdata, 32'd0);
        chk("err_mis_mem1", mem[1], 32'hDEADBEEF);
        @(negedge clk);
        chk("err_hold", {31'd0, rspErr}, 32'd1);
        xact(1'b0, 2'b11, 1'b0, 32'd0, 32'd0);
        chk("err_size_rsp_cyc", x_rsp_cyc, 32'd1);
        chk("err_size_rspErr", {31'd0, x_err}, 32'd1);
        xact(1'b0, 2'b01, 1'b0, 32'd1, 32'd0);
        chk("err_half_rspErr", {31'd0, x_err}, 32'd1);
        xact(1'b0, 2'b10, 1'b0, 32'd12, 32'd0);
        chk("after_err_rspErr", {31'd0, x_err}, 32'd0);
        chk("after_err_rspData", x_rdata, 32'h80F0007F);

        // Reset during the READ cycle of a byte store
        @(negedge clk);
        reqWrite = 1'b1;
        reqSize  = 2'b00;
        reqAddr  = 32'd8;
        reqData  = 32'h000000CC;
        reqValid = 1'b1;
        chk("rmw_rst_ready", {31'd0, reqReady}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        chk("rmw_rst_in_read", memAddr, 32'd8);
        rst = 1'b1;
        #1;
        chk("rmw_rst_memWrEn", {31'd0, memWrEn}, 32'd0);
        chk("rmw_rst_memAddr", memAddr, 32'd0);
        chk("rmw_rst_rspValid", {31'd0, rspValid}, 32'd0);
        chk("rmw_rst_reqReady", {31'd0, reqReady}, 32'd0);
        chk("rmw_rst_rspData", rspData, 32'd0);
        rst_wr = 0;
        rst_rsp = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (memWrEn)  rst_wr++;
            if (rspValid) rst_rsp++;
        end
        rst = 1'b0;
        #1;
        chk("rmw_rel_reqReady", {31'd0, reqReady}, 32'd1);
        chk("rmw_no_wr", rst_wr, 32'd0);
        chk("rmw_no_rsp", rst_rsp, 32'd0);
        chk("rmw_mem2", mem[2], 32'hBEEFAA44);
        xact(1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
        chk("rmw_next_load", x_rdata, 32'hBEEFAA44);
        chk("rmw_next_rsp_cyc", x_rsp_cyc, 32'd2);

        // Back-to-back loads with reqValid held high
        @(negedge clk);
        reqWrite = 1'b0;
        reqSize  = 2'b10;
        reqAddr  = 32'd4;
        reqValid = 1'b1;
        rdy_pat  = 6'd0;
        rsp_pat  = 6'd0;
        d1 = 32'd0;
        d2 = 32'd0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rdy_pat[c-1] = reqReady;
            rsp_pat[c-1] = rspValid;
            if (c == 2) d1 = rspData;
            if (c == 5) d2 = rspData;
            if (c == 3) reqAddr = 32'd12;
            if (c == 5) reqValid = 1'b0;
        end
        chk("b2b_ready_pat", {26'd0, rdy_pat}, 32'h24);
        chk("b2b_rsp_pat", {26'd0, rsp_pat}, 32'h12);
        chk("b2b_data1", d1, 32'hDEADBEEF);
        chk("b2b_data2", d2, 32'h80F0007F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

- Load/store initiator between the CPU datapath and the word-addressed `dataMemory` (1-cycle write on `posedge clk`, combinational read of `mem[addr/4]`).
- Adds a request/response handshake, byte/halfword/word accesses, little-endian lane extraction, and read-modify-write for sub-word stores.
- Flags misaligned or illegal-size requests instead of touching memory.

## Interface
- No parameters. Data and address width are fixed at 32.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reqValid`  in  1  CPU presents a request.
- `reqReady`  out  1  controller can accept a request.
- `reqWrite`  in  1  1 = store, 0 = load.
- `reqSize`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `reqSigned`  in  1  sign-extend sub-word loads (see Configuration).
- `reqAddr`  in  32  byte address.
- `reqData`  in  32  store data, right-aligned.
- `rspValid`  out  1  one-cycle response strobe.
- `rspData`  out  32  load result, right-aligned and extended; 0 for stores and errors.
- `rspErr`  out  1  misaligned address or illegal size.
- `memWrEn`  out  1  to `dataMemory` `regWrEn`.
- `memAddr`  out  32  to `dataMemory` `addr`; always word-aligned (`{reqAddr[31:2],2'b00}`).
- `memDataIn`  out  32  to `dataMemory` `dataIn`.
- `memDataOut`  in  32  from `dataMemory` `dataOut`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - `reqReady`=1. A request is accepted on a rising edge with `reqValid & reqReady`; all `req*` fields are latched.
  - Error if `reqSize`=11, or half with `addr[0]`=1, or word with `addr[1:0]`≠0. An error goes to RESP with `rspErr`=1 and no memory access.
  - Word store goes to WRITE.
  - Load or sub-word store goes to READ.
- READ:
  - Drives `memAddr`; captures `memDataOut` at the closing edge.
  - Load goes to RESP. Sub-word store goes to WRITE.
- WRITE:
  - `memWrEn`=1 and `memAddr` driven.
  - `memDataIn`:
    - word store: `reqData`;
    - byte store: captured word with lane `addr[1:0]` replaced by `reqData[7:0]`;
    - half store: captured word with lane `addr[1]` replaced by `reqData[15:0]`.
  - Then goes to RESP.
- RESP:
  - `rspValid`=1 for exactly one cycle, `reqReady`=0, then returns to IDLE.
  - `rspData`/`rspErr` are registered and hold until the next RESP.
- Lanes are little-endian: byte 0 = bits 7:0; half at `addr[1]`=1 = bits 31:16.
- Outside READ/WRITE: `memAddr`=0, `memDataIn`=0, `memWrEn`=0.
- The CPU must not change `req*` expectations mid-transaction; new requests are ignored unless in IDLE.

## Timing
- Cycles are counted after the accept edge:
  - load: READ cycle 1, `rspValid` cycle 2;
  - word store: WRITE cycle 1, `rspValid` cycle 2, memory updated at end of cycle 1;
  - sub-word store: READ 1, WRITE 2, `rspValid` 3;
  - error: `rspValid`+`rspErr` in cycle 1.
- Back-to-back: the next request can be accepted on the edge ending RESP+1, i.e. the first IDLE cycle.
- Reset values while `rst` is high: state IDLE, `reqReady`=0, `rspValid`=0, `rspData`=0, `rspErr`=0, `memWrEn`=0, `memAddr`=0, `memDataIn`=0. `reqReady` returns to 1 in the first cycle after `rst` falls.
- Reset mid-operation aborts the transaction immediately and asynchronously: `memWrEn` drops, so no write is committed unless its edge already occurred. No response is issued. Memory contents are untouched (memory has no reset).

## Configuration
- `LOAD_SIGNEXT_EN` defined: `reqSigned`=1 sign-extends byte/half loads from bit 7/15; `reqSigned`=0 zero-extends.
- Not defined: all loads zero-extend and `reqSigned` is ignored (port kept).
- Word loads are unaffected either way.

## Test plan
- Word store then load: store 0xDEADBEEF to addr 4, then load word at 4 → store `rspValid` 2 cycles after accept with `rspData`=0; load returns 0xDEADBEEF; mem[1]=0xDEADBEEF.
- Byte RMW: mem[2]=0x11223344; store byte 0xAA to addr 9 → `memWrEn` only in cycle 2 with `memDataIn`=0x1122AA44; response in cycle 3.
- Signed/unsigned loads: mem[3]=0x80F0007F.
  - Byte load at addr 12 → 0x0000007F.
  - Byte load at addr 14, `reqSigned`=1 → 0xFFFFFFF0 with `LOAD_SIGNEXT_EN`, 0x000000F0 without.
  - Half load at addr 14, signed → 0xFFFF80F0 with macro.
- Errors:
  - Word store at addr 6 → `rspErr`=1 in cycle 1, `memWrEn` never asserted, mem[1] unchanged.
  - `reqSize`=11 at addr 0 → same error behaviour.
- Reset mid-RMW: assert `rst` during the READ cycle of a byte store to addr 8 → no `memWrEn`, no `rspValid`, all outputs 0, mem[2] unchanged; after release `reqReady`=1 and the next load completes normally.
- Handshake: hold `reqValid`=1 continuously for two loads → `reqReady` low from accept through RESP; second accept on the first IDLE edge; exactly one `rspValid` pulse per request.
